i2c_expander_poller: RTL and testbench
======================================

// Module: i2c_expander_poller
// PURPOSE
//  Parametrised multi-device I2C GPIO-expander manager (PCA9554-style register map).
//  Sits between user logic and the register-level I2C transaction controller.
//  Configures NUM_DEV expanders after reset, then keeps them in sync:
//   - writes changed output bytes;
//   - polls input bytes on a fixed interval;
//   - flags input changes via irq;
//   - detects hung or NACKed transactions with a timeout.
// PARAMETERS
//  NUM_DEV      2         number of expanders, 1..8; device i at 7-bit address ADDR_BASE+i
//  ADDR_BASE    7'h20     I2C address of device 0
//  IO_DIR       16'hA8A8  NUM_DEV*8 bits, written to reg 0x03 of each device (1=input), byte i = device i
//  POLL_CYC     50000     clk cycles between input-poll rounds, >=16
//  STARTUP_CYC  100       clk cycles after reset release before first transaction
//  TIMEOUT_CYC  100000    max clk cycles waiting for xact_done/xact_err
// PORTS
//  clk          in   1           system clock
//  reset        in   1           asynchronous reset, active high
//  out_val      in   NUM_DEV*8   desired output-register byte per device
//  in_val       out  NUM_DEV*8   last input-register byte read per device
//  in_chg       out  NUM_DEV     1-cycle pulse per device whose in_val changed
//  irq          out  1           sticky OR of in_chg; cleared by irq_clr
//  irq_clr      in   1           clears irq (set wins if same cycle)
//  dev_err      out  NUM_DEV     sticky per-device NACK/timeout flag, cleared by irq_clr
//  ready        out  1           high when init done and FSM in IDLE
//  xact_wr      out  1           register write request (level)
//  xact_rd      out  1           register read request (level)
//  xact_dev     out  7           target I2C address
//  xact_reg     out  8           register address
//  xact_wdata   out  8           write data
//  xact_rdata   in   8           read data, valid with xact_done
//  xact_done    in   1           1-cycle completion pulse
//  xact_err     in   1           1-cycle NACK pulse (terminates the request)
// BEHAVIOUR
//  Reset values: all outputs 0; FSM=STARTUP; shadow bytes 0; timers 0.
//  Reset asserted mid-transaction: request drops immediately, all state lost, full re-init.
//  Handshake:
//   - Exactly one of xact_wr/xact_rd high; xact_dev/reg/wdata stable while high.
//   - Request drops the cycle after xact_done, xact_err or timeout; >=1 idle cycle between requests.
//  States:
//   - STARTUP: counts STARTUP_CYC -> CFG.
//   - CFG: for idx 0..NUM_DEV-1, write reg 0x03 = IO_DIR byte idx, then reg 0x01 = out_val byte idx
//     (shadow <- value written); after last device -> IDLE.
//   - IDLE: priority order:
//     1. any device with out_val byte != shadow (lowest idx first) -> WR_OUT;
//     2. poll pending -> RD_IN starting at idx 0.
//   - WR_OUT: write reg 0x01 = out_val byte captured at launch; shadow <- captured byte on done.
//     -> IDLE. A change during the write is caught by the next IDLE compare.
//   - RD_IN: read reg 0x00 of idx. On done, in_val byte <- rdata; in_chg[idx] pulses if it differed.
//     Next idx; after last -> IDLE and clear poll pending.
//  Poll timer:
//   - free-runs once in IDLE/RD_IN/WR_OUT; wraps at POLL_CYC-1, setting poll pending.
//   - a tick during an active round is dropped, not queued twice.
//  Errors:
//   - xact_err or timeout sets dev_err[idx] and irq.
//   - a failed write leaves shadow unchanged (retried from IDLE); a failed read keeps the old in_val.
//   - a failed CFG step still advances.
//  ready = (state==IDLE); it is 0 through STARTUP and CFG.
// TESTING
//  1. NUM_DEV=2, reset release -> after 100 clk: writes (0x20,0x03,0xA8), (0x20,0x01,out0),
//     (0x21,0x03,0xA8), (0x21,0x01,out1), then ready=1.
//  2. out_val byte1 0x00->0x05 while idle -> one write (0x21,0x01,0x05); no further write while unchanged.
//  3. Poll with device0 rdata 0x80 (was 0x00) -> in_val[7:0]=0x80, in_chg=2'b01 one cycle, irq=1;
//     irq_clr -> irq=0.
//  4. xact_err on device1 read -> dev_err=2'b10, in_val byte1 unchanged, FSM returns to IDLE.
//  5. No xact_done for TIMEOUT_CYC -> request drops, dev_err set, next device serviced.
//  6. reset pulsed during WR_OUT -> xact_wr=0 same cycle, full STARTUP/CFG sequence repeats.

Source files
------------

// File: rtl/i2c_expander_poller_if.sv
// Register-level I2C transaction bus between the expander poller (master)
// and the I2C transaction controller (slave).
//   xact_wr / xact_rd   level request, exactly one high while a request is open
//   xact_dev            7-bit target address
//   xact_reg            register address
//   xact_wdata          write data
//   xact_rdata          read data, valid with xact_done
//   xact_done           1-cycle completion pulse
//   xact_err            1-cycle NACK pulse, terminates the request
interface i2c_expander_poller_if;
    logic       xact_wr;
    logic       xact_rd;
    logic [6:0] xact_dev;
    logic [7:0] xact_reg;
    logic [7:0] xact_wdata;
    logic [7:0] xact_rdata;
    logic       xact_done;
    logic       xact_err;

    modport master (
        output xact_wr, xact_rd, xact_dev, xact_reg, xact_wdata,
        input  xact_rdata, xact_done, xact_err
    );

    modport slave (
        input  xact_wr, xact_rd, xact_dev, xact_reg, xact_wdata,
        output xact_rdata, xact_done, xact_err
    );
endinterface

// File: rtl/i2c_expander_poller.sv
// Multi-device PCA9554-style GPIO expander manager.
// After reset it waits STARTUP_CYC, configures each expander (direction reg
// then output reg), then in IDLE writes any output byte that differs from the
// last value written and polls input bytes every POLL_CYC cycles.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   out_val      desired output byte per device (byte i = device i)
//   in_val       last input byte read per device
//   in_chg       1-cycle pulse per device whose in_val changed
//   irq          sticky: input change or device error; cleared by irq_clr
//   irq_clr      clears irq and dev_err (a same-cycle set wins)
//   dev_err      sticky per-device NACK/timeout flag
//   ready        high in IDLE
//   bus          transaction controller interface (master side)
module i2c_expander_poller #(
    parameter int                   NUM_DEV     = 2,
    parameter logic [6:0]           ADDR_BASE   = 7'h20,
    parameter logic [NUM_DEV*8-1:0] IO_DIR      = 16'hA8A8,
    parameter int                   POLL_CYC    = 50000,
    parameter int                   STARTUP_CYC = 100,
    parameter int                   TIMEOUT_CYC = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_DEV*8-1:0] out_val,
    output logic [NUM_DEV*8-1:0] in_val,
    output logic [NUM_DEV-1:0]   in_chg,
    output logic                 irq,
    input  logic                 irq_clr,
    output logic [NUM_DEV-1:0]   dev_err,
    output logic                 ready,
    i2c_expander_poller_if.master bus
);
    localparam int IW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

    typedef enum logic [2:0] {ST_STARTUP, ST_CFG, ST_IDLE, ST_WR, ST_RD} state_t;
    state_t state, state_n;

    logic [7:0]    outb   [NUM_DEV];
    logic [7:0]    dirb   [NUM_DEV];
    logic [7:0]    shadow [NUM_DEV];
    logic [7:0]    in_q   [NUM_DEV];

    logic [IW-1:0] idx, idx_n;
    logic          step, step_n;      // CFG sub-step: 0 = direction, 1 = output
    logic          busy;              // request currently presented on the bus
    logic          wr_q;
    logic [7:0]    reg_q, wdata_q;
    logic [31:0]   start_cnt, tmr, poll_cnt;
    logic          poll_pend;

    logic          launch, round_end;
    logic          l_wr;
    logic [7:0]    l_reg, l_wdata;
    logic          tmo, fin, ok, fail, last, tick, chg_hit;
    logic          diff_any;
    logic [IW-1:0] diff_idx;

    for (genvar g = 0; g < NUM_DEV; g++) begin : g_dev
        assign outb[g]           = out_val[g*8 +: 8];
        assign dirb[g]           = IO_DIR[g*8 +: 8];
        assign in_val[g*8 +: 8]  = in_q[g];
    end

    assign tmo     = busy && (tmr == 32'(TIMEOUT_CYC - 1));
    assign fin     = busy && (bus.xact_done || bus.xact_err || tmo);
    // An error pulse takes precedence over a coincident done.
    assign ok      = busy && bus.xact_done && !bus.xact_err;
    assign fail    = fin && !ok;
    assign last    = (idx == IW'(NUM_DEV - 1));
    assign tick    = (state inside {ST_IDLE, ST_WR, ST_RD}) && (poll_cnt == 32'(POLL_CYC - 1));
    assign chg_hit = ok && !wr_q && (bus.xact_rdata != in_q[idx]);

    assign ready          = (state == ST_IDLE);
    assign bus.xact_wr    = busy && wr_q;
    assign bus.xact_rd    = busy && !wr_q;
    assign bus.xact_dev   = busy ? (ADDR_BASE + 7'(idx)) : 7'h00;
    assign bus.xact_reg   = reg_q;
    assign bus.xact_wdata = wdata_q;

    // Lowest-index device whose desired output differs from what was written.
    always_comb begin
        diff_any = 1'b0;
        diff_idx = '0;
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if (outb[i] != shadow[i]) begin
                diff_any = 1'b1;
                diff_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_STARTUP;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        step_n    = step;
        launch    = 1'b0;
        round_end = 1'b0;
        l_wr      = 1'b1;
        l_reg     = 8'h01;
        l_wdata   = outb[idx];
        case (state)
            ST_STARTUP: begin
                if (start_cnt == 32'(STARTUP_CYC - 1)) begin
                    state_n = ST_CFG;
                    idx_n   = '0;
                    step_n  = 1'b0;
                end
            end
            ST_CFG: begin
                l_reg   = step ? 8'h01 : 8'h03;
                l_wdata = step ? outb[idx] : dirb[idx];
                if (!busy) launch = 1'b1;
                else if (fin) begin
                    // failed steps advance too; a failed output write is
                    // retried from IDLE because shadow stays stale
                    if (!step) step_n = 1'b1;
                    else begin
                        step_n = 1'b0;
                        if (last) state_n = ST_IDLE;
                        else      idx_n   = idx + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (diff_any) begin
                    state_n = ST_WR;
                    idx_n   = diff_idx;
                end else if (poll_pend) begin
                    state_n = ST_RD;
                    idx_n   = '0;
                end
            end
            ST_WR: begin
                if (!busy)    launch  = 1'b1;
                else if (fin) state_n = ST_IDLE;
            end
            ST_RD: begin
                l_wr    = 1'b0;
                l_reg   = 8'h00;
                l_wdata = 8'h00;
                if (!busy) launch = 1'b1;
                else if (fin) begin
                    if (last) begin
                        state_n   = ST_IDLE;
                        round_end = 1'b1;
                    end else idx_n = idx + 1'b1;
                end
            end
            default: state_n = ST_STARTUP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            step      <= 1'b0;
            busy      <= 1'b0;
            wr_q      <= 1'b0;
            reg_q     <= 8'h00;
            wdata_q   <= 8'h00;
            start_cnt <= '0;
            tmr       <= '0;
            poll_cnt  <= '0;
            poll_pend <= 1'b0;
            in_chg    <= '0;
            irq       <= 1'b0;
            dev_err   <= '0;
            for (int i = 0; i < NUM_DEV; i++) begin
                shadow[i] <= 8'h00;
                in_q[i]   <= 8'h00;
            end
        end else begin
            idx    <= idx_n;
            step   <= step_n;
            in_chg <= '0;

            if (state == ST_STARTUP) start_cnt <= start_cnt + 1'b1;

            if (launch) begin
                busy    <= 1'b1;
                wr_q    <= l_wr;
                reg_q   <= l_reg;
                wdata_q <= l_wdata;
            end else if (fin) begin
                busy    <= 1'b0;
            end
            tmr <= (busy && !fin) ? tmr + 1'b1 : '0;

            // only output-register writes update the shadow
            if (ok && wr_q && reg_q == 8'h01) shadow[idx] <= wdata_q;

            if (ok && !wr_q) begin
                in_q[idx] <= bus.xact_rdata;
                if (chg_hit) in_chg[idx] <= 1'b1;
            end

            for (int i = 0; i < NUM_DEV; i++)
                dev_err[i] <= (dev_err[i] && !irq_clr) || (fail && idx == IW'(i));
            irq <= (irq && !irq_clr) || fail || chg_hit;

            if (state inside {ST_IDLE, ST_WR, ST_RD})
                poll_cnt <= tick ? '0 : poll_cnt + 1'b1;
            // a tick landing inside a poll round is dropped
            if (round_end) poll_pend <= 1'b0;
            if (tick && state != ST_RD) poll_pend <= 1'b1;
        end
    end
endmodule

// File: tb/tb_i2c_expander_poller.sv
// Directed bench for i2c_expander_poller: a small responder model acks
// requests after a fixed latency, logs completed writes, and can NACK reads
// or hang to force a timeout.
module tb_i2c_expander_poller;
    localparam int NUM_DEV = 2;
    localparam int LAT     = 3;
    localparam int TMO     = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] out_val;
    logic [15:0] in_val;
    logic [1:0]  in_chg;
    logic        irq;
    logic        irq_clr;
    logic [1:0]  dev_err;
    logic        ready;

    i2c_expander_poller_if bus ();

    i2c_expander_poller #(
        .NUM_DEV(NUM_DEV), .ADDR_BASE(7'h20), .IO_DIR(16'hA8A8),
        .POLL_CYC(400), .STARTUP_CYC(100), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset(rst), .out_val(out_val), .in_val(in_val),
        .in_chg(in_chg), .irq(irq), .irq_clr(irq_clr), .dev_err(dev_err),
        .ready(ready), .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // responder controls
    logic        hang, err_en;
    logic [6:0]  err_addr;
    logic [7:0]  dev_in [2];
    logic [22:0] wlog [$];
    int          cnt, cyc, first_req_cyc;
    logic        served, both_hi;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= 0;
            cyc           <= 0;
            first_req_cyc <= 0;
            served        <= 1'b0;
            bus.xact_done <= 1'b0;
            bus.xact_err  <= 1'b0;
            bus.xact_rdata <= 8'h00;
        end else begin
            cyc           <= cyc + 1;
            bus.xact_done <= 1'b0;
            bus.xact_err  <= 1'b0;
            if (bus.xact_wr || bus.xact_rd) begin
                if (first_req_cyc == 0) first_req_cyc <= cyc;
                if (!served) begin
                    if (cnt == LAT) begin
                        cnt <= 0;
                        if (!hang) begin
                            served <= 1'b1;
                            if (bus.xact_rd && err_en && bus.xact_dev == err_addr)
                                bus.xact_err <= 1'b1;
                            else begin
                                bus.xact_done  <= 1'b1;
                                bus.xact_rdata <= dev_in[bus.xact_dev[0]];
                                if (bus.xact_wr)
                                    wlog.push_back({bus.xact_dev, bus.xact_reg, bus.xact_wdata});
                            end
                        end
                    end else cnt <= cnt + 1;
                end
            end else served <= 1'b0;
        end
    end

    always @(negedge clk) if (bus.xact_wr && bus.xact_rd) both_hi <= 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] wl(input int i);
        return (wlog.size() > i) ? wlog[i] : 23'h7FFFFF;
    endfunction

    task automatic wait_ready(input int n);
        for (int i = 0; i < n && !ready; i++) @(negedge clk);
    endtask

    task automatic pulse_clr();
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; out_val = 16'h0011; irq_clr = 1'b0;
        hang = 1'b0; err_en = 1'b0; err_addr = 7'h00; both_hi = 1'b0;
        dev_in[0] = 8'h00; dev_in[1] = 8'h00;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_ready", ready, 0);
        chk("rst_irq", irq, 0);
        chk("rst_dev_err", dev_err, 0);
        chk("rst_in_val", in_val, 0);
        chk("rst_wr_rd", {bus.xact_wr, bus.xact_rd}, 0);
        chk("rst_dev", bus.xact_dev, 0);

        // 1. startup and configuration sequence
        rst = 1'b0;
        wait_ready(2000);
        chk("cfg_ready", ready, 1);
        chk("startup_delay", (first_req_cyc >= 100 && first_req_cyc <= 104), 1);
        chk("cfg_count", wlog.size(), 4);
        chk("cfg_w0", wl(0), {7'h20, 8'h03, 8'hA8});
        chk("cfg_w1", wl(1), {7'h20, 8'h01, 8'h11});
        chk("cfg_w2", wl(2), {7'h21, 8'h03, 8'hA8});
        chk("cfg_w3", wl(3), {7'h21, 8'h01, 8'h00});

        // 2. output change while idle
        wlog.delete();
        out_val[15:8] = 8'h05;
        for (int i = 0; i < 100 && wlog.size() == 0; i++) @(negedge clk);
        chk("wr_out_w0", wl(0), {7'h21, 8'h01, 8'h05});
        repeat (100) @(negedge clk);
        chk("wr_out_once", wlog.size(), 1);
        chk("wr_out_irq", irq, 0);

        // 3. poll picks up an input change on device 0
        dev_in[0] = 8'h80;
        for (int i = 0; i < 1000 && in_chg == 2'b00; i++) @(negedge clk);
        chk("poll_chg", in_chg, 2'b01);
        chk("poll_in0", in_val[7:0], 8'h80);
        chk("poll_in1", in_val[15:8], 8'h00);
        @(negedge clk);
        chk("poll_chg_pulse", in_chg, 2'b00);
        chk("poll_irq", irq, 1);
        pulse_clr();
        chk("irq_clr", irq, 0);

        // 4. NACK on device 1 read
        err_en = 1'b1; err_addr = 7'h21; dev_in[1] = 8'h33;
        for (int i = 0; i < 1000 && dev_err == 2'b00; i++) @(negedge clk);
        chk("nack_dev_err", dev_err, 2'b10);
        chk("nack_in1_kept", in_val[15:8], 8'h00);
        chk("nack_in0", in_val[7:0], 8'h80);
        chk("nack_irq", irq, 1);
        wait_ready(20);
        chk("nack_idle", ready, 1);
        err_en = 1'b0; dev_in[1] = 8'h00;
        pulse_clr();
        chk("nack_clr_err", dev_err, 2'b00);
        chk("nack_clr_irq", irq, 0);

        // 5. hung read times out, next device is serviced
        hang = 1'b1;
        for (int i = 0; i < 1000 && !bus.xact_rd; i++) @(negedge clk);
        chk("tmo_start_dev", bus.xact_dev, 7'h20);
        n = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!bus.xact_rd) break;
            n++;
        end
        chk("tmo_len", n, TMO);
        chk("tmo_dropped", bus.xact_rd, 0);
        chk("tmo_dev_err", dev_err, 2'b01);
        chk("tmo_irq", irq, 1);
        for (int i = 0; i < 10 && !bus.xact_rd; i++) @(negedge clk);
        chk("tmo_next_rd", bus.xact_rd, 1);
        chk("tmo_next_dev", bus.xact_dev, 7'h21);
        hang = 1'b0;
        wait_ready(50);
        chk("tmo_idle", ready, 1);
        pulse_clr();

        // 6. reset in the middle of an output write
        out_val[7:0] = 8'h7E;
        for (int i = 0; i < 50 && !bus.xact_wr; i++) @(negedge clk);
        chk("rstwr_dev", bus.xact_dev, 7'h20);
        chk("rstwr_data", bus.xact_wdata, 8'h7E);
        rst = 1'b1;
        #1;
        chk("rstwr_drop", bus.xact_wr, 0);
        chk("rstwr_ready", ready, 0);
        wlog.delete();
        @(negedge clk);
        rst = 1'b0;
        wait_ready(2000);
        chk("recfg_ready", ready, 1);
        chk("recfg_delay", (first_req_cyc >= 100 && first_req_cyc <= 104), 1);
        chk("recfg_count", wlog.size(), 4);
        chk("recfg_w0", wl(0), {7'h20, 8'h03, 8'hA8});
        chk("recfg_w1", wl(1), {7'h20, 8'h01, 8'h7E});
        chk("recfg_w2", wl(2), {7'h21, 8'h03, 8'hA8});
        chk("recfg_w3", wl(3), {7'h21, 8'h01, 8'h05});
        chk("recfg_in_val", in_val, 16'h0000);
        chk("one_hot_req", both_hi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
